// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared definitions for the two-master memory bus arbiter:
//               FSM state encoding, default bus widths shared with the
//               MemoryUnit and CPU, and the timeout response fill value.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Default bus geometry, shared with MemoryUnit and CPU
    localparam int unsigned BUS_ADDR_W = 27;
    localparam int unsigned BUS_DATA_W = 32;

    // Arbiter FSM encoding
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_BUSY    = 2'd1;
    localparam logic [1:0] ARB_RELEASE = 2'd2;

    // A timed-out transaction returns a word with every bit set to this value
    localparam logic TIMEOUT_FILL_BIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Pure combinational two-way round-robin pick. A lone request
//               wins outright; on a tie the master that was not granted last
//               wins.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // Select the winning master index from the live request lines
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master arbiter sharing the single MemoryUnit bus port
//               between the CPU (master 0) and a second master (master 1).
//               Transactions are serialised with round-robin fairness, the
//               winning request is latched onto the bus, and the response is
//               routed back to the granted master only.
//               Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//               (forced completion after TIMEOUT_CYCLES in BUSY, adds the
//               sticky timeout_err output).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = BUS_ADDR_W,
    parameter int unsigned DATA_W         = BUS_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              nreset,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data,
    input  logic              m0_we,
    input  logic              m0_start,
    output logic [DATA_W-1:0] m0_q,
    output logic              m0_done,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data,
    input  logic              m1_we,
    input  logic              m1_start,
    output logic [DATA_W-1:0] m1_q,
    output logic              m1_done,

    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_we,
    output logic              bus_start,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done,

    output logic              grant,
`ifdef BUS_ARBITER_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              busy
);

    logic [1:0]        state_q,     state_d;
    logic              last_q,      last_d;
    logic              grant_q,     grant_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_data_q,  bus_data_d;
    logic              bus_we_q,    bus_we_d;
    logic              bus_start_q, bus_start_d;
    logic [DATA_W-1:0] m0_rdata_q,  m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,  m1_rdata_d;
    logic              m0_done_q,   m0_done_d;
    logic              m1_done_q,   m1_done_d;

    logic              rr_winner;
    logic              rr_valid;
    logic              complete;
    logic [DATA_W-1:0] complete_data;

    bus_arbiter_rr u_rr (
        .req    ({m1_start, m0_start}),
        .last   (last_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned      TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             tmo_hit;

    assign tmo_hit = (state_q == ARB_BUSY) && !bus_done && (tmo_cnt_q == TMO_LAST);

    // Count BUSY cycles from zero on each grant; latch a sticky error on expiry
    always_comb begin
        tmo_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
        if (state_q == ARB_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (tmo_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    // Timeout counter and sticky error flag
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // The limit is accepted for interface compatibility but has no effect here
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Decide whether the in-flight transaction finishes this cycle and with what data
    always_comb begin
        complete      = 1'b0;
        complete_data = bus_q;
        if (state_q == ARB_BUSY) begin
            if (bus_done) begin
                complete = 1'b1;
            end
`ifdef BUS_ARBITER_TIMEOUT_EN
            else if (tmo_hit) begin
                complete      = 1'b1;
                complete_data = {DATA_W{TIMEOUT_FILL_BIT}};
            end
`endif
        end
    end

    // Arbiter FSM next-state: grant in IDLE, wait in BUSY, one dead cycle in RELEASE
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        bus_we_d    = bus_we_q;
        bus_start_d = bus_start_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_done_d   = 1'b0;
        m1_done_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (rr_valid) begin
                    state_d     = ARB_BUSY;
                    grant_d     = rr_winner;
                    last_d      = rr_winner;
                    bus_addr_d  = rr_winner ? m1_addr : m0_addr;
                    bus_data_d  = rr_winner ? m1_data : m0_data;
                    bus_we_d    = rr_winner ? m1_we   : m0_we;
                    bus_start_d = 1'b1;
                end
            end
            ARB_BUSY: begin
                // Master lines are deliberately ignored here: the latched copy drives the bus
                if (complete) begin
                    state_d     = ARB_RELEASE;
                    bus_start_d = 1'b0;
                    if (grant_q) begin
                        m1_rdata_d = complete_data;
                        m1_done_d  = 1'b1;
                    end else begin
                        m0_rdata_d = complete_data;
                        m0_done_d  = 1'b1;
                    end
                end
            end
            ARB_RELEASE: begin
                // Guarantees the MemoryUnit sees bus_start low before the next grant
                state_d = ARB_IDLE;
            end
            default: begin
                state_d     = ARB_IDLE;
                bus_start_d = 1'b0;
            end
        endcase
    end

    // State and output registers; last resets to 1 so master 0 wins the first tie
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ARB_IDLE;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_start_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            bus_we_q    <= bus_we_d;
            bus_start_q <= bus_start_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_done_q   <= m0_done_d;
            m1_done_q   <= m1_done_d;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_data  = bus_data_q;
    assign bus_we    = bus_we_q;
    assign bus_start = bus_start_q;
    assign m0_q      = m0_rdata_q;
    assign m1_q      = m1_rdata_q;
    assign m0_done   = m0_done_q;
    assign m1_done   = m1_done_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. Two protocol-following
//               master agents and a MemoryUnit agent generate randomized
//               traffic; a transaction-level model predicts every output.
//               Optional feature macro: BUS_ARBITER_TIMEOUT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int AW = 27;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [AW-1:0] ma  [2];
    logic [DW-1:0] md  [2];
    logic          mwe [2];
    logic          mst [2];
    logic [DW-1:0] m0_q, m1_q;
    logic          m0_done, m1_done;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data;
    logic          bus_we, bus_start;
    logic [DW-1:0] bus_q;
    logic          bus_done;
    logic          grant, busy;
`ifdef BUS_ARBITER_TIMEOUT_EN
    logic          timeout_err;
`endif

    bus_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .m0_addr   (ma[0]),
        .m0_data   (md[0]),
        .m0_we     (mwe[0]),
        .m0_start  (mst[0]),
        .m0_q      (m0_q),
        .m0_done   (m0_done),
        .m1_addr   (ma[1]),
        .m1_data   (md[1]),
        .m1_we     (mwe[1]),
        .m1_start  (mst[1]),
        .m1_q      (m1_q),
        .m1_done   (m1_done),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_we    (bus_we),
        .bus_start (bus_start),
        .bus_q     (bus_q),
        .bus_done  (bus_done),
        .grant     (grant),
`ifdef BUS_ARBITER_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- transaction-level reference model ----------------
    int            k;          // posedges since reset release
    bit            m_busy;     // a bus transaction is outstanding
    int            m_free;     // earliest posedge at which a new grant may happen
    bit            m_last;
    bit            m_owner;
    int            m_gcyc;     // posedge of the current grant
    bit            e_grant;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_we;
    logic [DW-1:0] e_q [2];
    bit            e_done [2];
    bit            e_rel;
    bit            e_tmo;

    // ---------------- agent state and phase configuration ----------------
    int            mem_cnt, mem_lat;
    bit            mem_hang, spur_en, drop_en, dir_addr_en, dir_q_en;
    int            dir_lat;
    logic [DW-1:0] dir_q;
    int            gmax;
    int            left [2];
    int            gap  [2];
    bit            mw   [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; m_busy = 0; m_free = 0; m_last = 1'b1; m_owner = 0; m_gcyc = 0;
        e_grant = 0; e_addr = '0; e_data = '0; e_we = 1'b0;
        e_q[0] = '0; e_q[1] = '0; e_done[0] = 0; e_done[1] = 0; e_rel = 0; e_tmo = 0;
    endtask

    task automatic model_finish(input logic [DW-1:0] q);
        e_q[m_owner]    = q;
        e_done[m_owner] = 1'b1;
        m_busy = 0;
        m_free = k + 2;
        e_rel  = 1'b1;
    endtask

    // Apply the arbitration rules to what the DUT sampled at this posedge
    task automatic model_step();
        bit w;
        e_done[0] = 0; e_done[1] = 0; e_rel = 0;
        if (m_busy && bus_done) begin
            model_finish(bus_q);
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (m_busy && (k - m_gcyc) == TO) begin
            model_finish({DW{1'b1}});
            e_tmo = 1'b1;
        end
`endif
        else if (!m_busy && k >= m_free && (mst[0] || mst[1])) begin
            w = (mst[0] && mst[1]) ? ~m_last : mst[1];
            m_busy = 1; m_owner = w; m_last = w; e_grant = w; m_gcyc = k;
            e_addr = ma[w]; e_data = md[w]; e_we = mwe[w];
            mem_cnt = 0;
            mem_lat = (dir_lat != 0) ? dir_lat : int'($urandom_range(1, 4));
        end
    endtask

    task automatic compare_outputs();
        check_eq("bus_start", bus_start, m_busy);
        check_eq("busy",      busy,      m_busy || e_rel);
        check_eq("grant",     grant,     e_grant);
        check_eq("bus_addr",  bus_addr,  e_addr);
        check_eq("bus_data",  bus_data,  e_data);
        check_eq("bus_we",    bus_we,    e_we);
        check_eq("m0_done",   m0_done,   e_done[0]);
        check_eq("m1_done",   m1_done,   e_done[1]);
        check_eq("m0_q",      m0_q,      e_q[0]);
        check_eq("m1_q",      m1_q,      e_q[1]);
`ifdef BUS_ARBITER_TIMEOUT_EN
        check_eq("timeout_err", timeout_err, e_tmo);
`endif
    endtask

    task automatic drive_idle();
        for (int i = 0; i < 2; i++) begin
            mst[i] = 1'b0; ma[i] = '0; md[i] = '0; mwe[i] = 1'b0; mw[i] = 0; gap[i] = 0;
        end
        bus_done = 1'b0; bus_q = '0; mem_cnt = 0;
    endtask

    // MemoryUnit and master agents react to the cycle just observed
    task automatic drive_agents();
        if (m_busy) begin
            mem_cnt++;
            if (!mem_hang && mem_cnt == mem_lat) begin
                bus_done = 1'b1;
                bus_q    = dir_q_en ? dir_q : DW'($urandom);
            end else begin
                bus_done = 1'b0;
                bus_q    = DW'($urandom);
            end
        end else begin
            bus_done = spur_en && ($urandom_range(0, 7) == 0);
            bus_q    = DW'($urandom);
        end
        for (int i = 0; i < 2; i++) begin
            if (mw[i]) begin
                if (e_done[i]) begin
                    mw[i] = 0; mst[i] = 1'b0; gap[i] = int'($urandom_range(0, gmax));
                end else if (drop_en && m_busy && m_owner == i && $urandom_range(0, 15) == 0) begin
                    mst[i] = 1'b0;
                end
            end else if (left[i] > 0) begin
                if (gap[i] == 0) begin
                    mw[i] = 1; mst[i] = 1'b1; left[i]--;
                    ma[i]  = (dir_addr_en && i == 0) ? AW'(27'h0000100) : AW'($urandom);
                    md[i]  = DW'($urandom);
                    mwe[i] = 1'($urandom_range(0, 1));
                end else begin
                    gap[i]--;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (nreset) begin
            k++;
            model_step();
        end
        @(negedge clk);
        compare_outputs();
        if (nreset) drive_agents();
        else        drive_idle();
    endtask

    task automatic cfg_default();
        mem_hang = 0; spur_en = 0; drop_en = 0; dir_addr_en = 0; dir_q_en = 0;
        dir_lat = 0; dir_q = '0; gmax = 0; left[0] = 0; left[1] = 0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) cycle();
        nreset = 1'b1;
    endtask

    int n_start, d0, d1, nlog, zeros;
    bit prev_start;
    int glog [8];
    int zlog [8];

    initial begin
        cfg_default();
        drive_idle();
        model_reset();

        // ---- single master read, latency 3 ----
        do_reset();
        left[0] = 1; dir_addr_en = 1; dir_lat = 3; dir_q_en = 1; dir_q = 32'hDEADBEEF;
        n_start = 0; d0 = 0; d1 = 0;
        repeat (14) begin
            cycle();
            n_start += int'(bus_start); d0 += int'(m0_done); d1 += int'(m1_done);
        end
        check_eq("t1_bus_start_cycles", n_start, 3);
        check_eq("t1_m0_done_pulses", d0, 1);
        check_eq("t1_m1_done_pulses", d1, 0);
        check_eq("t1_m0_q", m0_q, 32'hDEADBEEF);

        // ---- simultaneous start after reset, then fairness over 6 grants ----
        cfg_default();
        do_reset();
        left[0] = 3; left[1] = 3;
        nlog = 0; zeros = 0; prev_start = 0;
        repeat (70) begin
            cycle();
            if (bus_start && !prev_start) begin
                if (nlog < 8) begin glog[nlog] = int'(grant); zlog[nlog] = zeros; end
                nlog++;
            end
            zeros      = bus_start ? 0 : zeros + 1;
            prev_start = bus_start;
        end
        check_eq("t3_grant_count", nlog, 6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t3_grant_seq[%0d]", i), glog[i], i % 2);
            if (i > 0) check_eq($sformatf("t2_idle_gap[%0d]", i), zlog[i], 2);
        end

        // ---- randomized traffic: overlaps, spurious done, dropped starts ----
        cfg_default();
        do_reset();
        left[0] = 100000; left[1] = 100000; gmax = 4; spur_en = 1; drop_en = 1;
        repeat (500) cycle();

        // ---- reset in the middle of a transaction ----
        for (int t = 0; t < 50 && !m_busy; t++) cycle();
        check_eq("t5_reached_busy", m_busy, 1);
        #2 nreset = 1'b0;
        #1;
        check_eq("t5_async_bus_start", bus_start, 0);
        check_eq("t5_async_busy", busy, 0);
        check_eq("t5_async_m0_done", m0_done, 0);
        check_eq("t5_async_m1_done", m1_done, 0);
        cfg_default();
        do_reset();
        left[0] = 1;
        d0 = 0;
        repeat (15) begin
            cycle();
            d0 += int'(m0_done);
        end
        check_eq("t5_m0_after_reset", d0, 1);

        left[0] = 100000; left[1] = 100000; gmax = 3; spur_en = 1; drop_en = 1;
        repeat (400) cycle();

`ifdef BUS_ARBITER_TIMEOUT_EN
        // ---- MemoryUnit never answers: forced completion ----
        cfg_default();
        do_reset();
        mem_hang = 1; left[1] = 1;
        n_start = 0; d1 = 0;
        repeat (30) begin
            cycle();
            n_start += int'(bus_start); d1 += int'(m1_done);
        end
        check_eq("t6_busy_cycles", n_start, TO);
        check_eq("t6_m1_done_pulses", d1, 1);
        check_eq("t6_m1_q", m1_q, 32'hFFFFFFFF);
        check_eq("t6_timeout_err", timeout_err, 1);
        repeat (5) cycle();
        check_eq("t6_timeout_err_sticky", timeout_err, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
